// File: rtl/axi_master_arbiter.sv
// rtl/axi_master_arbiter.sv - shares one AXI4-Lite master port between two requesters
// Single outstanding transaction; round-robin or fixed-priority grant; sticky watchdog flag.
module axi_master_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             AXI_CLK,
  input  logic             RESETN,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_write,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0][3:0]  req_wstrb,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic             timeout_flag,
  input  logic             timeout_clr,
  output logic [31:0]      AXI_araddr,
  output logic [2:0]       AXI_arprot,
  output logic             AXI_arvalid,
  input  logic             AXI_arready,
  input  logic [31:0]      AXI_rdata,
  input  logic [1:0]       AXI_rresp,
  input  logic             AXI_rvalid,
  output logic             AXI_rready,
  output logic [31:0]      AXI_awaddr,
  output logic [2:0]       AXI_awprot,
  output logic             AXI_awvalid,
  input  logic             AXI_awready,
  output logic [31:0]      AXI_wdata,
  output logic [3:0]       AXI_wstrb,
  output logic             AXI_wvalid,
  input  logic             AXI_wready,
  input  logic [1:0]       AXI_bresp,
  input  logic             AXI_bvalid,
  output logic             AXI_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_D, S_WR_AW, S_WR_B, S_RESP
  } state_t;

  localparam logic [15:0] LP_TMO    = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] LP_TMO_M1 = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_grant;
  logic        r_last_grant;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [15:0] r_wd_cnt;
  logic        r_timeout;
  logic        w_any;
  logic        w_win;
  logic        w_unused;

  assign w_any    = |req_valid;
  assign w_unused = AXI_rresp[0] ^ AXI_bresp[0];

  always_comb begin
    w_win = 1'b0;
    if (PRIORITY_MODE == 1)
      w_win = ~req_valid[0];
    else if (&req_valid)
      w_win = ~r_last_grant;
    else
      w_win = req_valid[1];
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_ready[w_win] = 1'b1;
          w_next = req_write[w_win] ? S_WR_AW : S_RD_A;
        end
      end
      S_RD_A:  if (AXI_arready) w_next = S_RD_D;
      S_RD_D:  if (AXI_rvalid) w_next = S_RESP;
      // AW and W complete independently; leave once both have handshaken
      S_WR_AW: if ((r_aw_done || AXI_awready) && (r_w_done || AXI_wready)) w_next = S_WR_B;
      S_WR_B:  if (AXI_bvalid) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= w_win;
            r_addr    <= req_addr[w_win];
            r_wdata   <= req_wdata[w_win];
            r_wstrb   <= req_wstrb[w_win];
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_RD_D: begin
          if (AXI_rvalid) begin
            r_rdata <= AXI_rdata;
            r_err   <= AXI_rresp[1];
          end
        end
        S_WR_AW: begin
          if (AXI_awready) r_aw_done <= 1'b1;
          if (AXI_wready)  r_w_done  <= 1'b1;
        end
        S_WR_B: begin
          if (AXI_bvalid) begin
            r_rdata <= '0;
            r_err   <= AXI_bresp[1];
          end
        end
        S_RESP: r_last_grant <= r_grant;
        default: ;
      endcase
    end
  end

  // Watchdog only flags; the transaction is never aborted
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_wd_cnt <= '0;
      else if (r_wd_cnt != LP_TMO)
        r_wd_cnt <= r_wd_cnt + 16'd1;
      if (timeout_clr)
        r_timeout <= 1'b0;
      else if (r_state != S_IDLE && r_wd_cnt == LP_TMO_M1)
        r_timeout <= 1'b1;
    end
  end

  assign rsp_valid    = {(r_state == S_RESP) && r_grant, (r_state == S_RESP) && !r_grant};
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign busy         = (r_state != S_IDLE);
  assign timeout_flag = r_timeout;

  assign AXI_araddr  = r_addr;
  assign AXI_arprot  = 3'b000;
  assign AXI_arvalid = (r_state == S_RD_A);
  assign AXI_rready  = (r_state == S_RD_D);
  assign AXI_awaddr  = r_addr;
  assign AXI_awprot  = 3'b000;
  assign AXI_awvalid = (r_state == S_WR_AW) && !r_aw_done;
  assign AXI_wdata   = r_wdata;
  assign AXI_wstrb   = r_wstrb;
  assign AXI_wvalid  = (r_state == S_WR_AW) && !r_w_done;
  assign AXI_bready  = (r_state == S_WR_B);

endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb/tb_axi_master_arbiter.sv - directed bench for axi_master_arbiter
// dut0: round-robin, watchdog 16; dut1: fixed priority, shares all inputs with dut0.
module tb_axi_master_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [1:0]       req_valid, req_write;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][3:0]  req_wstrb;
  logic             timeout_clr;
  logic             arready, rvalid, awready, wready, bvalid;
  logic [31:0]      rdata;
  logic [1:0]       rresp, bresp;

  logic [1:0]  req_ready0, rsp_valid0, req_ready1, rsp_valid1;
  logic [31:0] rsp_rdata0, rsp_rdata1, araddr0, araddr1, awaddr0, awaddr1, wdata0, wdata1;
  logic        rsp_err0, rsp_err1, busy0, busy1, tflag0, tflag1;
  logic [2:0]  arprot0, arprot1, awprot0, awprot1;
  logic        arvalid0, arvalid1, rready0, rready1, awvalid0, awvalid1;
  logic        wvalid0, wvalid1, bready0, bready1;
  logic [3:0]  wstrb0, wstrb1;

  axi_master_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(16)) dut0 (
    .AXI_CLK(clk), .RESETN(resetn), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .busy(busy0), .timeout_flag(tflag0), .timeout_clr(timeout_clr),
    .AXI_araddr(araddr0), .AXI_arprot(arprot0), .AXI_arvalid(arvalid0), .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid), .AXI_rready(rready0),
    .AXI_awaddr(awaddr0), .AXI_awprot(awprot0), .AXI_awvalid(awvalid0), .AXI_awready(awready),
    .AXI_wdata(wdata0), .AXI_wstrb(wstrb0), .AXI_wvalid(wvalid0), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready0));

  axi_master_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(1024)) dut1 (
    .AXI_CLK(clk), .RESETN(resetn), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .busy(busy1), .timeout_flag(tflag1), .timeout_clr(timeout_clr),
    .AXI_araddr(araddr1), .AXI_arprot(arprot1), .AXI_arvalid(arvalid1), .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid), .AXI_rready(rready1),
    .AXI_awaddr(awaddr1), .AXI_awprot(awprot1), .AXI_awvalid(awvalid1), .AXI_awready(awready),
    .AXI_wdata(wdata1), .AXI_wstrb(wstrb1), .AXI_wvalid(wvalid1), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int          n_ar = 0, n_aw = 0, n_w = 0, n_r0 = 0, n_r1 = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  int          g0_n = 0, g1_n = 0;
  logic        g0_log [128];
  logic        g1_log [128];
  int          g0_cyc [128];

  always begin
    @(negedge clk);
    #2;
    if (arvalid0) n_ar++;
    if (awvalid0) n_aw++;
    if (wvalid0)  n_w++;
    if (rsp_valid0[0]) n_r0++;
    if (rsp_valid0[1]) n_r1++;
    if (arvalid0 && arready) cap_addr = araddr0;
    if (awvalid0 && awready) cap_addr = awaddr0;
    if (wvalid0 && wready) begin
      cap_wdata = wdata0;
      cap_wstrb = wstrb0;
    end
    if (|req_ready0 && g0_n < 128) begin
      g0_log[g0_n] = req_ready0[1];
      g0_cyc[g0_n] = cyc;
      g0_n++;
    end
    if (|req_ready1 && g1_n < 128) begin
      g1_log[g1_n] = req_ready1[1];
      g1_n++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int p, input string tag);
    int k;
    k = 0;
    while (!req_ready0[p] && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk($sformatf("%s_ready_seen", tag), 32'(k < 20), 1);
  endtask

  task automatic wait_rsp(input int p, input string tag);
    int k;
    k = 0;
    while (!rsp_valid0[p] && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk($sformatf("%s_rsp_seen", tag), 32'(k < 40), 1);
  endtask

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] sdata;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [6];
  vec_t post;

  task automatic run_vec(input vec_t v, input string tag);
    int s_ar, s_aw, s_w, s_r0, s_r1, t0;
    @(negedge clk);
    s_ar = n_ar; s_aw = n_aw; s_w = n_w; s_r0 = n_r0; s_r1 = n_r1;
    req_write[v.port] = v.wr;
    req_addr[v.port]  = v.addr;
    req_wdata[v.port] = v.wdata;
    req_wstrb[v.port] = v.strb;
    req_valid = v.port ? 2'b10 : 2'b01;
    rdata = v.sdata;
    rresp = v.resp;
    bresp = v.resp;
    #1;
    wait_ready(int'(v.port), tag);
    t0 = cyc;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    wait_rsp(int'(v.port), tag);
    chk($sformatf("%s_latency", tag), 32'(cyc - t0), 3);
    chk($sformatf("%s_rdata", tag), rsp_rdata0, v.exp_rdata);
    chk($sformatf("%s_err", tag), 32'(rsp_err0), 32'(v.exp_err));
    #2;
    chk($sformatf("%s_addr", tag), cap_addr, v.addr);
    if (v.wr) begin
      chk($sformatf("%s_wdata", tag), cap_wdata, v.wdata);
      chk($sformatf("%s_wstrb", tag), 32'(cap_wstrb), 32'(v.strb));
      chk($sformatf("%s_aw_cycles", tag), 32'(n_aw - s_aw), 1);
      chk($sformatf("%s_w_cycles", tag), 32'(n_w - s_w), 1);
    end else begin
      chk($sformatf("%s_ar_cycles", tag), 32'(n_ar - s_ar), 1);
    end
    chk($sformatf("%s_rsp0_pulses", tag), 32'(n_r0 - s_r0), 32'(v.port == 1'b0));
    chk($sformatf("%s_rsp1_pulses", tag), 32'(n_r1 - s_r1), 32'(v.port == 1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    int s_aw, s_w, s_r0, s_r1, t0, base0, base1, k;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b10, 32'h0BAD_F00D, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 4'hF, 32'h1111_1111, 2'b11, 32'h0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_3004, 32'h5A5A_0000, 4'h5, 32'h2222_2222, 2'b00, 32'h0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_4008, 32'h0, 4'h0, 32'h1234_5678, 2'b01, 32'h1234_5678, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_400C, 32'h0, 4'h0, 32'h8765_4321, 2'b00, 32'h8765_4321, 1'b0};
    post   = '{1'b0, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0};

    resetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    timeout_clr = 1'b0;
    arready = 1'b1; rvalid = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    rdata = '0; rresp = '0; bresp = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_req_ready", 32'(req_ready0), 0);
    chk("rst_rsp_valid", 32'(rsp_valid0), 0);
    chk("rst_rsp_rdata", rsp_rdata0, 0);
    chk("rst_timeout_flag", 32'(tflag0), 0);
    chk("rst_arvalid", 32'(arvalid0), 0);
    chk("rst_awvalid", 32'(awvalid0), 0);
    chk("rst_wvalid", 32'(wvalid0), 0);
    chk("rst_bready", 32'(bready0), 0);
    chk("arprot", 32'(arprot0), 0);
    chk("awprot", 32'(awprot0), 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // port 1 write with awready held off for two cycles
    @(negedge clk);
    s_aw = n_aw; s_w = n_w; s_r0 = n_r0; s_r1 = n_r1;
    awready = 1'b0;
    bresp = 2'b00;
    req_write[1] = 1'b1; req_addr[1] = 32'h0000_2004;
    req_wdata[1] = 32'h1234_5678; req_wstrb[1] = 4'b0011;
    req_valid = 2'b10;
    #1;
    wait_ready(1, "slow_aw");
    t0 = cyc;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    awready = 1'b1;
    #1;
    wait_rsp(1, "slow_aw");
    chk("slow_aw_latency", 32'(cyc - t0), 5);
    chk("slow_aw_err", 32'(rsp_err0), 0);
    #2;
    chk("slow_aw_awvalid_cycles", 32'(n_aw - s_aw), 3);
    chk("slow_aw_wvalid_cycles", 32'(n_w - s_w), 1);
    chk("slow_aw_addr", cap_addr, 32'h0000_2004);
    chk("slow_aw_wdata", cap_wdata, 32'h1234_5678);
    chk("slow_aw_wstrb", 32'(cap_wstrb), 32'h3);
    chk("slow_aw_rsp1", 32'(n_r1 - s_r1), 1);
    chk("slow_aw_rsp0", 32'(n_r0 - s_r0), 0);

    // both ports requesting continuously; last grant so far went to port 1
    @(negedge clk);
    req_write = 2'b00;
    req_addr[0] = 32'h0000_0100; req_addr[1] = 32'h0000_0200;
    rresp = 2'b00;
    base0 = g0_n; base1 = g1_n;
    req_valid = 2'b11;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      #3;
      if (g0_n - base0 >= 8) break;
      k++;
    end
    chk("arb_eight_grants", 32'(k < 100), 1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(g0_log[base0 + i]), 32'(i % 2));
      chk($sformatf("prio_grant%0d", i), 32'(g1_log[base1 + i]), 0);
    end
    for (int i = 0; i < 7; i++)
      chk($sformatf("rr_spacing%0d", i), 32'(g0_cyc[base0 + i + 1] - g0_cyc[base0 + i]), 4);

    // watchdog: rvalid withheld well past 16 busy cycles
    @(negedge clk);
    rvalid = 1'b0;
    rdata = 32'h600D_600D;
    req_write[0] = 1'b0; req_addr[0] = 32'h0000_7000;
    req_valid = 2'b01;
    #1;
    wait_ready(0, "wdog");
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 2'b00;
      #1;
      if (i == 16) chk("wdog_flag_before", 32'(tflag0), 0);
      if (i == 17) chk("wdog_flag_rise", 32'(tflag0), 1);
    end
    repeat (5) @(negedge clk);
    rvalid = 1'b1;
    #1;
    wait_rsp(0, "wdog");
    chk("wdog_rdata", rsp_rdata0, 32'h600D_600D);
    chk("wdog_flag_sticky", 32'(tflag0), 1);
    chk("wdog_long_limit_flag", 32'(tflag1), 0);
    @(negedge clk);
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    #1;
    chk("wdog_flag_cleared", 32'(tflag0), 0);

    // reset while waiting for the write response
    @(negedge clk);
    bvalid = 1'b0;
    req_write[0] = 1'b1; req_addr[0] = 32'h0000_8000;
    req_wdata[0] = 32'hFFFF_0000; req_wstrb[0] = 4'hC;
    req_valid = 2'b01;
    #1;
    wait_ready(0, "mid_rst");
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("mid_rst_in_wr_b", 32'(bready0), 1);
    s_r0 = n_r0;
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_arvalid", 32'(arvalid0), 0);
    chk("mid_rst_awvalid", 32'(awvalid0), 0);
    chk("mid_rst_wvalid", 32'(wvalid0), 0);
    chk("mid_rst_bready", 32'(bready0), 0);
    chk("mid_rst_busy", 32'(busy0), 0);
    resetn = 1'b1;
    bvalid = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("mid_rst_no_rsp", 32'(n_r0 - s_r0), 0);
    run_vec(post, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
